noc_tok_lnk_buf: RTL and testbench
==================================

NOC_TOK_LNK_BUF -- requirements
Module: noc_tok_lnk_buf

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of independent token link channels, legal range 1..8.
REQ-002 SHALL have parameter DW, default 42: flit data width; narrower channels tie their upper bits to 0.
REQ-003 SHALL have parameter DEPTH, default 4: per-channel FIFO entries; power of two, at least 2.
REQ-004 SHALL have one clock and an asynchronous active-low reset: i_noc_clk input 1 (sole clock), then i_noc_rst_n input 1 (asynchronous, active-low).
REQ-005 SHALL have scan_en, input, width 1: DFT only, with no functional effect.
REQ-006 SHALL have the ingress ports, indexed per channel: i_ingress_data input [NUM_CH][DW]; i_ingress_head, i_ingress_tail and i_ingress_vld inputs [NUM_CH]; o_ingress_rdy output [NUM_CH].
REQ-007 SHALL have the egress ports, indexed per channel: o_egress_data output [NUM_CH][DW]; o_egress_head, o_egress_tail and o_egress_vld outputs [NUM_CH]; i_egress_rdy input [NUM_CH].
REQ-008 SHALL have the power ports: i_pwr_tok_idle_req input 1 (request to idle); o_pwr_tok_idle_ack output 1; o_pwr_tok_idle_val output 1 (block is quiescent).
REQ-009 SHALL have o_fill, output [NUM_CH][$clog2(DEPTH+1)]: per-channel FIFO occupancy.

Function
REQ-010 Each channel SHALL buffer {data, head, tail} in a DEPTH-entry first-word-fall-through FIFO, with channels fully independent.
REQ-011 A flit SHALL transfer on a cycle where vld&&rdy is 1, on both ingress and egress.
REQ-012 Ingress-to-egress latency SHALL be 1 cycle: a flit accepted in cycle N gives o_egress_vld=1 in cycle N+1 when the FIFO was empty.
REQ-013 o_egress_vld SHALL equal FIFO not-empty, and egress data/head/tail SHALL hold stable while vld=1 and rdy=0.
REQ-014 A full FIFO SHALL drive o_ingress_rdy=0, even when an egress pop occurs in the same cycle; there is no same-cycle full pass-through.
REQ-015 A simultaneous push and pop on a non-full, non-empty FIFO SHALL leave o_fill unchanged.
REQ-016 Read and write pointers SHALL wrap modulo DEPTH, and o_fill SHALL range 0..DEPTH.
REQ-017 Each channel SHALL keep an in_pkt flag: set on accepting head=1 with tail=0, cleared on accepting tail=1; a single-flit packet (head=tail=1) leaves it clear.
REQ-018 The power FSM SHALL have states RUN, FENCE, DRAIN, IDLE.
REQ-019 RUN: o_ingress_rdy[c] = not-full. On idle_req=1, go to FENCE.
REQ-020 FENCE: o_ingress_rdy[c] = not-full && in_pkt[c], so open packets complete and new heads are refused. When all in_pkt are 0, go to DRAIN.
REQ-021 DRAIN: o_ingress_rdy=0 and egress continues. When all FIFOs are empty, go to IDLE.
REQ-022 IDLE: o_ingress_rdy=0, o_pwr_tok_idle_ack=1, o_pwr_tok_idle_val=1. When idle_req=0, go to RUN the next cycle with ack=0 and val=0.
REQ-023 idle_req=0 while in FENCE or DRAIN SHALL return the FSM to RUN next cycle (abort) without asserting ack.
REQ-024 When in RUN, o_pwr_tok_idle_val SHALL also be 1 if all FIFOs are empty, all in_pkt are 0 and all ingress vld are 0; o_pwr_tok_idle_ack SHALL be 1 only in IDLE.
REQ-025 The FSM SHALL take exactly one transition per cycle, with no state skipping.

Reset
REQ-026 On reset: FSM=RUN, pointers=0, o_fill=0, in_pkt=0, o_egress_vld=0, o_pwr_tok_idle_ack=0.
REQ-027 On reset, o_pwr_tok_idle_val SHALL be 1 (empty), per REQ-024.
REQ-028 Reset asserted mid-packet or mid-drain SHALL discard all buffered flits immediately and asynchronously.
REQ-029 o_ingress_rdy SHALL be 0 while reset is asserted and SHALL follow REQ-019 from the first cycle after deassertion.

Structure
REQ-030 A shared package noc_tok_pkg SHALL hold the pwr FSM state enum, the flit struct {data, head, tail} and default parameter constants.
REQ-031 There SHALL be one sub-module, noc_tok_ch_fifo, instantiated NUM_CH times, which owns the FIFO, o_fill and in_pkt.
REQ-032 The top level SHALL hold only the power FSM and the per-channel rdy gating.

Verification
REQ-033 NUM_CH=2, DEPTH=4: push 4 single-flit packets on ch0 with egress rdy=0 -> o_fill[0]=4, o_ingress_rdy[0]=0, ch1 unaffected; then rdy=1 -> flits out in order, one per cycle.
REQ-034 Streaming with push+pop every cycle at fill=2 for 16 cycles -> o_fill stays 2, pointers wrap 4 times, no data loss.
REQ-035 idle_req raised after a head on ch1 (3-flit packet) -> middle and tail accepted, a new head on ch0 refused, then DRAIN, ack=1 once both fill=0.
REQ-036 idle_req dropped during DRAIN -> RUN next cycle, ack never 1, ingress rdy restored.
REQ-037 Reset asserted with fill=3 and in_pkt=1 -> egress vld=0 and fill=0 immediately; after release, a new head is accepted in the first cycle.
REQ-038 Full four-phase handshake: req=1 -> ack=1 -> req=0 -> ack=0 the next cycle and traffic resumes.

Source files
------------

// File: rtl/noc_tok_pkg.sv
// noc_tok_pkg: shared types and default parameters for the token link buffer.
package noc_tok_pkg;
    localparam int NUM_CH_DEF = 2;
    localparam int DW_DEF     = 42;
    localparam int DEPTH_DEF  = 4;
    typedef enum logic [1:0] {
        PWR_RUN   = 2'd0,
        PWR_FENCE = 2'd1,
        PWR_DRAIN = 2'd2,
        PWR_IDLE  = 2'd3
    } pwr_state_e;
    typedef struct packed {
        logic [DW_DEF-1:0] data;
        logic              head;
        logic              tail;
    } flit_t;
endpackage

// File: rtl/noc_tok_ch_fifo.sv
// noc_tok_ch_fifo: one channel's first-word-fall-through flit FIFO with
// occupancy count and open-packet tracking.
module noc_tok_ch_fifo
    import noc_tok_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int AW   = $clog2(DEPTH),
    localparam int FW   = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          head_i,
    input  logic          tail_i,
    input  logic          pop_rdy_i,
    output logic [DW-1:0] data_o,
    output logic          head_o,
    output logic          tail_o,
    output logic          vld_o,
    output logic          full_o,
    output logic [FW-1:0] fill_o,
    output logic          in_pkt_o
);
    logic [DW+1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [FW-1:0] fill_q, fill_d;
    logic          in_pkt_q, in_pkt_d, pop;

    assign vld_o    = fill_q != '0;
    assign full_o   = fill_q == FW'(DEPTH);
    assign fill_o   = fill_q;
    assign in_pkt_o = in_pkt_q;
    assign pop      = pop_rdy_i && vld_o;
    assign {data_o, head_o, tail_o} = mem_q[rd_q];

    always_comb begin
        wr_d     = push_i ? wr_q + 1'b1 : wr_q;
        rd_d     = pop ? rd_q + 1'b1 : rd_q;
        fill_d   = fill_q + FW'(push_i) - FW'(pop);
        in_pkt_d = !push_i ? in_pkt_q : tail_i ? 1'b0 : head_i ? 1'b1 : in_pkt_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q     <= '0;
            rd_q     <= '0;
            fill_q   <= '0;
            in_pkt_q <= 1'b0;
        end else begin
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            fill_q   <= fill_d;
            in_pkt_q <= in_pkt_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_q] <= {data_i, head_i, tail_i};
    end
endmodule

// File: rtl/noc_tok_lnk_buf.sv
// noc_tok_lnk_buf: multi-channel token link buffer with a power fence/drain
// FSM gating ingress ready.
module noc_tok_lnk_buf
    import noc_tok_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int DW     = DW_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    localparam int FW    = $clog2(DEPTH + 1)
) (
    input  logic                     i_noc_clk,
    input  logic                     i_noc_rst_n,
    input  logic                     scan_en,
    input  logic [NUM_CH-1:0][DW-1:0] i_ingress_data,
    input  logic [NUM_CH-1:0]         i_ingress_head,
    input  logic [NUM_CH-1:0]         i_ingress_tail,
    input  logic [NUM_CH-1:0]         i_ingress_vld,
    output logic [NUM_CH-1:0]         o_ingress_rdy,
    output logic [NUM_CH-1:0][DW-1:0] o_egress_data,
    output logic [NUM_CH-1:0]         o_egress_head,
    output logic [NUM_CH-1:0]         o_egress_tail,
    output logic [NUM_CH-1:0]         o_egress_vld,
    input  logic [NUM_CH-1:0]         i_egress_rdy,
    input  logic                      i_pwr_tok_idle_req,
    output logic                      o_pwr_tok_idle_ack,
    output logic                      o_pwr_tok_idle_val,
    output logic [NUM_CH-1:0][FW-1:0] o_fill
);
    pwr_state_e        state_q, state_d;
    logic [NUM_CH-1:0] full, in_pkt, vld;
    logic              unused_scan;

    assign unused_scan  = scan_en;
    assign o_egress_vld = vld;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        // Ready is held low while reset is asserted, independent of the FSM.
        assign o_ingress_rdy[c] = i_noc_rst_n && !full[c] &&
                                  (state_q == PWR_RUN || (state_q == PWR_FENCE && in_pkt[c]));
        noc_tok_ch_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
            .clk_i     (i_noc_clk),
            .rst_ni    (i_noc_rst_n),
            .push_i    (i_ingress_vld[c] && o_ingress_rdy[c]),
            .data_i    (i_ingress_data[c]),
            .head_i    (i_ingress_head[c]),
            .tail_i    (i_ingress_tail[c]),
            .pop_rdy_i (i_egress_rdy[c]),
            .data_o    (o_egress_data[c]),
            .head_o    (o_egress_head[c]),
            .tail_o    (o_egress_tail[c]),
            .vld_o     (vld[c]),
            .full_o    (full[c]),
            .fill_o    (o_fill[c]),
            .in_pkt_o  (in_pkt[c])
        );
    end

    always_comb begin
        state_d = !i_pwr_tok_idle_req ? PWR_RUN :
                  state_q == PWR_RUN   ? PWR_FENCE :
                  state_q == PWR_FENCE ? (|in_pkt ? PWR_FENCE : PWR_DRAIN) :
                  state_q == PWR_DRAIN ? (|vld ? PWR_DRAIN : PWR_IDLE) : PWR_IDLE;
    end

    always_ff @(posedge i_noc_clk or negedge i_noc_rst_n) begin
        if (!i_noc_rst_n) state_q <= PWR_RUN;
        else              state_q <= state_d;
    end

    assign o_pwr_tok_idle_ack = state_q == PWR_IDLE;
    assign o_pwr_tok_idle_val = o_pwr_tok_idle_ack ||
                                (state_q == PWR_RUN && !(|vld) && !(|in_pkt) && !(|i_ingress_vld));
endmodule

// File: tb/tb_noc_tok_lnk_buf.sv
// tb_noc_tok_lnk_buf: directed and random traffic checked against a
// queue-based reference model of the link buffer and its power handshake.
module tb_noc_tok_lnk_buf;
    import noc_tok_pkg::*;
    localparam int NC = 2;
    localparam int W  = 42;
    localparam int D  = 4;
    localparam int M_RUN = 0, M_FENCE = 1, M_DRAIN = 2, M_IDLE = 3;

    logic clk = 1'b0, rst_n = 1'b0, scan_en = 1'b0;
    logic [NC-1:0][W-1:0] in_data = '0, eg_data;
    logic [NC-1:0] in_head = '0, in_tail = '0, in_vld = '0, in_rdy;
    logic [NC-1:0] eg_head, eg_tail, eg_vld, eg_rdy = '0;
    logic req = 1'b0, ack, val;
    logic [NC-1:0][2:0] fill;
    int n_chk = 0, n_fail = 0;

    flit_t q[NC][$];
    bit inpkt[NC];
    int mode = M_RUN;

    always #5 clk = ~clk;

    noc_tok_lnk_buf #(.NUM_CH(NC), .DW(W), .DEPTH(D)) dut (
        .i_noc_clk(clk), .i_noc_rst_n(rst_n), .scan_en(scan_en),
        .i_ingress_data(in_data), .i_ingress_head(in_head), .i_ingress_tail(in_tail),
        .i_ingress_vld(in_vld), .o_ingress_rdy(in_rdy),
        .o_egress_data(eg_data), .o_egress_head(eg_head), .o_egress_tail(eg_tail),
        .o_egress_vld(eg_vld), .i_egress_rdy(eg_rdy),
        .i_pwr_tok_idle_req(req), .o_pwr_tok_idle_ack(ack), .o_pwr_tok_idle_val(val),
        .o_fill(fill)
    );

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_data();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[W-1:0];
    endfunction

    task automatic drive(int c, bit h, bit t);
        in_vld[c]  = 1'b1;
        in_head[c] = h;
        in_tail[c] = t;
        in_data[c] = rnd_data();
    endtask

    task automatic idle_in();
        in_vld  = '0;
        in_head = '0;
        in_tail = '0;
    endtask

    // Check outputs against the model, then advance the model one clock.
    task automatic cycle();
        bit er[NC], pop[NC];
        bit empty_all, open_any;
        #1;
        empty_all = 1;
        open_any  = 0;
        for (int c = 0; c < NC; c++) begin
            er[c] = (q[c].size() < D) &&
                    (mode == M_RUN || (mode == M_FENCE && inpkt[c]));
            chk($sformatf("rdy%0d", c), in_rdy[c], er[c]);
            chk($sformatf("vld%0d", c), eg_vld[c], q[c].size() > 0);
            chk($sformatf("fill%0d", c), fill[c], q[c].size());
            if (q[c].size() > 0)
                chk($sformatf("flit%0d", c), {eg_data[c], eg_head[c], eg_tail[c]}, q[c][0]);
            if (q[c].size() > 0) empty_all = 0;
            if (inpkt[c]) open_any = 1;
        end
        chk("ack", ack, mode == M_IDLE);
        chk("val", val, mode == M_IDLE || (mode == M_RUN && empty_all && !open_any && in_vld == '0));
        if (!req) mode = M_RUN;
        else if (mode == M_RUN) mode = M_FENCE;
        else if (mode == M_FENCE) mode = open_any ? M_FENCE : M_DRAIN;
        else if (mode == M_DRAIN) mode = empty_all ? M_IDLE : M_DRAIN;
        for (int c = 0; c < NC; c++) begin
            pop[c] = q[c].size() > 0 && eg_rdy[c];
            if (pop[c]) void'(q[c].pop_front());
            if (in_vld[c] && er[c]) begin
                q[c].push_back('{data: in_data[c], head: in_head[c], tail: in_tail[c]});
                if (in_tail[c]) inpkt[c] = 0;
                else if (in_head[c]) inpkt[c] = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_rdy", in_rdy, '0);
        chk("rst_vld", eg_vld, '0);
        chk("rst_fill", fill, '0);
        chk("rst_ack", ack, 0);
        chk("rst_val", val, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Fill ch0 to capacity with egress stalled, then drain in order.
        for (int i = 0; i < 4; i++) begin drive(0, 1, 1); cycle(); end
        drive(0, 1, 1); cycle();
        idle_in();
        eg_rdy = 2'b01;
        for (int i = 0; i < 5; i++) cycle();

        // Steady streaming on ch1 at fill 2.
        eg_rdy = '0;
        for (int i = 0; i < 2; i++) begin drive(1, 1, 1); cycle(); end
        eg_rdy = 2'b10;
        for (int i = 0; i < 16; i++) begin drive(1, 1, 1); cycle(); end
        idle_in();
        for (int i = 0; i < 3; i++) cycle();

        // Fence lets the open ch1 packet finish while refusing a new ch0 head.
        eg_rdy = '0;
        drive(1, 1, 0); cycle();
        idle_in(); req = 1'b1; cycle();
        drive(1, 0, 0); drive(0, 1, 0); cycle();
        drive(1, 0, 1); drive(0, 1, 0); cycle();
        idle_in(); eg_rdy = '1;
        for (int i = 0; i < 20 && mode != M_IDLE; i++) cycle();
        chk("ack_reached", ack, 1);
        chk("idle_fill", fill, '0);

        // Release: ack drops next cycle and traffic resumes.
        req = 1'b0; cycle();
        drive(0, 1, 0); cycle();
        drive(0, 0, 1); cycle();
        idle_in(); cycle(); cycle();

        // Abort during drain.
        eg_rdy = '0;
        drive(0, 1, 1); cycle();
        drive(0, 1, 1); cycle();
        idle_in(); req = 1'b1; cycle();
        cycle(); cycle();
        chk("drain_rdy", in_rdy, '0);
        req = 1'b0; cycle();
        drive(1, 1, 1); cycle();
        idle_in(); eg_rdy = '1;
        for (int i = 0; i < 4; i++) cycle();

        // Random traffic with occasional idle requests.
        for (int i = 0; i < 300; i++) begin
            for (int c = 0; c < NC; c++) begin
                if ($urandom_range(0, 1) == 1) drive(c, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
                else in_vld[c] = 1'b0;
                eg_rdy[c] = $urandom_range(0, 3) != 0;
            end
            if ($urandom_range(0, 15) == 0) req = ~req;
            cycle();
        end
        idle_in(); req = 1'b0; eg_rdy = '1;
        for (int i = 0; i < 8; i++) cycle();

        // Asynchronous reset mid-packet with three flits buffered.
        eg_rdy = '0;
        drive(0, 1, 0); cycle();
        drive(0, 0, 0); cycle();
        drive(0, 0, 0); cycle();
        idle_in();
        chk("pre_rst_fill", fill[0], 3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_vld", eg_vld, '0);
        chk("async_fill", fill, '0);
        chk("async_rdy", in_rdy, '0);
        for (int c = 0; c < NC; c++) begin q[c].delete(); inpkt[c] = 0; end
        mode = M_RUN;
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(0, 1, 0); cycle();
        drive(0, 0, 1); eg_rdy = '1; cycle();
        idle_in();
        for (int i = 0; i < 3; i++) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end
endmodule
